// File: rtl/uart_rx_frame_ctrl.sv
// ---------------------------------------------------------------------------
// uart_rx_frame_ctrl
//   Frame controller behind uart_rx. Parses [SOF][LEN][PAYLOAD x LEN][CSUM]
//   frames from the received byte stream, buffers payload speculatively in a
//   FIFO and only exposes it downstream once the checksum of the frame is
//   good. Bad, timed-out or overflowing frames are rolled back and reported.
//
// Ports
//   clk, reset      clock, async active-high reset
//   s_tick          oversampling tick (timeout time base)
//   rx_done_tick    byte strobe from uart_rx; rx_data / rx_parity_err qualify it
//   m_data/m_last   payload byte out / last byte of its frame
//   m_valid/m_ready valid/ready handshake of the payload stream
//   frame_done      1-cycle pulse, frame committed
//   err_pulse       1-cycle pulse, frame dropped
//   err_code        drop cause, held: 1 PARITY 2 LEN 3 CSUM 4 TIMEOUT 5 OVERFLOW
//   good_cnt/drop_cnt  saturating frame counters (only with RXF_STATS_EN)
//
// Configuration macro: RXF_STATS_EN adds good_cnt / drop_cnt.
// ---------------------------------------------------------------------------
module uart_rx_frame_ctrl #(
    parameter int unsigned DEPTH         = 16,
    parameter int unsigned MAX_LEN       = 15,
    parameter logic [7:0]  SOF           = 8'h7E,
    parameter int unsigned TIMEOUT_TICKS = 640
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_tick,
    input  logic        rx_done_tick,
    input  logic [7:0]  rx_data,
    input  logic        rx_parity_err,
    output logic [7:0]  m_data,
    output logic        m_last,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        frame_done,
    output logic        err_pulse,
`ifdef RXF_STATS_EN
    output logic [15:0] good_cnt,
    output logic [15:0] drop_cnt,
`endif
    output logic [2:0]  err_code
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [PW-1:0] DEPTH_P  = PW'(DEPTH);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_TICKS - 1);
    localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

    localparam logic [2:0] E_PARITY   = 3'd1;
    localparam logic [2:0] E_LEN      = 3'd2;
    localparam logic [2:0] E_CSUM     = 3'd3;
    localparam logic [2:0] E_TIMEOUT  = 3'd4;
    localparam logic [2:0] E_OVERFLOW = 3'd5;

    typedef enum logic [1:0] {ST_IDLE, ST_LEN, ST_PAYLOAD, ST_CSUM} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   cm_ptr_q, cm_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [7:0]      sum_q, sum_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            frame_done_q, frame_done_d;
    logic            err_pulse_q, err_pulse_d;
    logic [2:0]      err_code_q, err_code_d;

    // Payload storage: {last, data}. No reset needed, pointers gate visibility.
    logic [8:0]      mem_q [DEPTH];
    logic            mem_we;
    logic [8:0]      mem_wdata;

    logic            pop;
    logic            full;
    logic            drop;
    logic [2:0]      drop_code;

    assign m_valid    = (rd_ptr_q != cm_ptr_q);
    assign m_data     = mem_q[rd_ptr_q[AW-1:0]][7:0];
    assign m_last     = mem_q[rd_ptr_q[AW-1:0]][8];
    assign pop        = m_valid & m_ready;
    // Occupancy against rd_ptr so unread committed data is never overwritten.
    assign full       = ((wr_ptr_q - rd_ptr_q) == DEPTH_P);
    assign frame_done = frame_done_q;
    assign err_pulse  = err_pulse_q;
    assign err_code   = err_code_q;

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        cm_ptr_d     = cm_ptr_q;
        rd_ptr_d     = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        cnt_d        = cnt_q;
        sum_d        = sum_q;
        tmo_d        = tmo_q;
        frame_done_d = 1'b0;
        err_pulse_d  = 1'b0;
        err_code_d   = err_code_q;
        mem_we       = 1'b0;
        mem_wdata    = {(cnt_q == 8'd1), rx_data};
        drop         = 1'b0;
        drop_code    = 3'd0;

        if (state_q == ST_IDLE || rx_done_tick) begin
            tmo_d = '0;
        end else if (s_tick) begin
            tmo_d = tmo_q + 1'b1;
        end

        if (rx_done_tick) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (rx_data == SOF && !rx_parity_err) begin
                        state_d = ST_LEN;
                        sum_d   = 8'd0;
                    end
                end
                ST_LEN: begin
                    if (rx_parity_err) begin
                        drop = 1'b1; drop_code = E_PARITY;
                    end else if (rx_data != 8'd0 && rx_data <= MAX_LEN_B) begin
                        state_d = ST_PAYLOAD;
                        cnt_d   = rx_data;
                        sum_d   = rx_data;
                    end else begin
                        drop = 1'b1; drop_code = E_LEN;
                    end
                end
                ST_PAYLOAD: begin
                    if (rx_parity_err) begin
                        drop = 1'b1; drop_code = E_PARITY;
                    end else if (full) begin
                        drop = 1'b1; drop_code = E_OVERFLOW;
                    end else begin
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        sum_d    = sum_q + rx_data;
                        cnt_d    = cnt_q - 8'd1;
                        if (cnt_q == 8'd1) state_d = ST_CSUM;
                    end
                end
                ST_CSUM: begin
                    if (rx_parity_err) begin
                        drop = 1'b1; drop_code = E_PARITY;
                    end else if ((sum_q + rx_data) == 8'd0) begin
                        cm_ptr_d     = wr_ptr_q;
                        frame_done_d = 1'b1;
                        state_d      = ST_IDLE;
                    end else begin
                        drop = 1'b1; drop_code = E_CSUM;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE && s_tick && tmo_q == TMO_LAST) begin
            // A byte arriving on the expiry tick takes the branch above instead.
            drop = 1'b1; drop_code = E_TIMEOUT;
        end

        if (drop) begin
            wr_ptr_d    = cm_ptr_q;
            err_pulse_d = 1'b1;
            err_code_d  = drop_code;
            state_d     = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            cm_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            sum_q        <= '0;
            tmo_q        <= '0;
            frame_done_q <= 1'b0;
            err_pulse_q  <= 1'b0;
            err_code_q   <= 3'd0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            cm_ptr_q     <= cm_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            sum_q        <= sum_d;
            tmo_q        <= tmo_d;
            frame_done_q <= frame_done_d;
            err_pulse_q  <= err_pulse_d;
            err_code_q   <= err_code_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[wr_ptr_q[AW-1:0]] <= mem_wdata;
    end

`ifdef RXF_STATS_EN
    logic [15:0] good_cnt_q, good_cnt_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        good_cnt_d = good_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (frame_done_q && good_cnt_q != 16'hFFFF) good_cnt_d = good_cnt_q + 16'd1;
        if (err_pulse_q  && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            good_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            good_cnt_q <= good_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign good_cnt = good_cnt_q;
    assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
module tb_uart_rx_frame_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       s_tick;
    logic       rx_done_tick;
    logic [7:0] rx_data;
    logic       rx_parity_err;
    logic [7:0] m_data;
    logic       m_last;
    logic       m_valid;
    logic       m_ready;
    logic       frame_done;
    logic       err_pulse;
    logic [2:0] err_code;

    int n_cmp = 0;
    int n_err = 0;

    // Observed traffic, gathered on the falling edge.
    logic [7:0] got_data[$];
    logic       got_last[$];
    int         fd_cnt, ep_cnt, mv_cnt;

    uart_rx_frame_ctrl #(
        .DEPTH(4), .MAX_LEN(15), .SOF(8'h7E), .TIMEOUT_TICKS(640)
    ) dut (
        .clk(clk), .reset(reset), .s_tick(s_tick),
        .rx_done_tick(rx_done_tick), .rx_data(rx_data), .rx_parity_err(rx_parity_err),
        .m_data(m_data), .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready),
        .frame_done(frame_done), .err_pulse(err_pulse), .err_code(err_code)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (m_valid && m_ready) begin
            got_data.push_back(m_data);
            got_last.push_back(m_last);
        end
        if (m_valid)    mv_cnt++;
        if (frame_done) fd_cnt++;
        if (err_pulse)  ep_cnt++;
    end

    task automatic clr();
        got_data.delete();
        got_last.delete();
        fd_cnt = 0; ep_cnt = 0; mv_cnt = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One byte strobe followed by one quiet cycle; starts and ends at posedge+1.
    task automatic send(input logic [7:0] b, input logic p = 1'b0);
        rx_data = b; rx_parity_err = p; rx_done_tick = 1'b1;
        @(posedge clk); #1;
        rx_done_tick = 1'b0; rx_parity_err = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic tick();
        s_tick = 1'b1;
        @(posedge clk); #1;
        s_tick = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++; if (m_valid !== 1'b0)    begin n_err++; $display("FAIL reset_m_valid got %b want 0", m_valid); end
        n_cmp++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
        n_cmp++; if (err_pulse !== 1'b0)  begin n_err++; $display("FAIL reset_err_pulse got %b want 0", err_pulse); end
        n_cmp++; if (err_code !== 3'd0)   begin n_err++; $display("FAIL reset_err_code got %0d want 0", err_code); end
    endtask

    task automatic test_good_frame();
        logic [7:0] exp_d [3];
        logic       exp_l [3];
        exp_d = '{8'h11, 8'h22, 8'h33};
        exp_l = '{1'b0, 1'b0, 1'b1};
        clr(); m_ready = 1'b1;
        send(8'h7E); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h97);
        idle(6);
        n_cmp++; if (fd_cnt != 1) begin n_err++; $display("FAIL good_frame_done got %0d want 1", fd_cnt); end
        n_cmp++; if (ep_cnt != 0) begin n_err++; $display("FAIL good_err_pulse got %0d want 0", ep_cnt); end
        n_cmp++; if (got_data.size() != 3) begin n_err++; $display("FAIL good_count got %0d want 3", got_data.size()); end
        for (int i = 0; i < 3 && i < got_data.size(); i++) begin
            n_cmp++; if (got_data[i] !== exp_d[i]) begin n_err++; $display("FAIL good_data[%0d] got %h want %h", i, got_data[i], exp_d[i]); end
            n_cmp++; if (got_last[i] !== exp_l[i]) begin n_err++; $display("FAIL good_last[%0d] got %b want %b", i, got_last[i], exp_l[i]); end
        end
    endtask

    task automatic test_bad_csum();
        clr(); m_ready = 1'b1;
        send(8'h7E); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h98);
        idle(4);
        n_cmp++; if (ep_cnt != 1)     begin n_err++; $display("FAIL csum_err_pulse got %0d want 1", ep_cnt); end
        n_cmp++; if (err_code !== 3'd3) begin n_err++; $display("FAIL csum_err_code got %0d want 3", err_code); end
        n_cmp++; if (mv_cnt != 0)     begin n_err++; $display("FAIL csum_m_valid cycles got %0d want 0", mv_cnt); end
        n_cmp++; if (fd_cnt != 0)     begin n_err++; $display("FAIL csum_frame_done got %0d want 0", fd_cnt); end
        clr();
        send(8'h7E); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h97);
        idle(6);
        n_cmp++; if (got_data.size() != 3) begin n_err++; $display("FAIL csum_next_count got %0d want 3", got_data.size()); end
        else begin
            n_cmp++; if (got_data[0] !== 8'h11 || got_data[2] !== 8'h33 || got_last[2] !== 1'b1)
                begin n_err++; $display("FAIL csum_next_data got %h..%h/%b want 11..33/1", got_data[0], got_data[2], got_last[2]); end
        end
    endtask

    task automatic test_len();
        clr(); m_ready = 1'b1;
        send(8'h7E); send(8'h00); idle(1);
        n_cmp++; if (ep_cnt != 1 || err_code !== 3'd2) begin n_err++; $display("FAIL len_zero got pulses %0d code %0d want 1 2", ep_cnt, err_code); end
        send(8'h7E); send(8'h10); idle(1);
        n_cmp++; if (ep_cnt != 2 || err_code !== 3'd2) begin n_err++; $display("FAIL len_16 got pulses %0d code %0d want 2 2", ep_cnt, err_code); end
        n_cmp++; if (mv_cnt != 0) begin n_err++; $display("FAIL len_m_valid got %0d want 0", mv_cnt); end
    endtask

    task automatic test_stray();
        clr(); m_ready = 1'b1;
        send(8'h55); send(8'hAA); idle(3);
        n_cmp++; if (ep_cnt != 0 || fd_cnt != 0 || mv_cnt != 0)
            begin n_err++; $display("FAIL stray got ep %0d fd %0d mv %0d want 0 0 0", ep_cnt, fd_cnt, mv_cnt); end
        // Parser still hunting for SOF: the next frame parses normally.
        send(8'h7E); send(8'h01); send(8'h42); send(8'hBD); idle(4);
        n_cmp++; if (got_data.size() != 1 || got_data[0] !== 8'h42)
            begin n_err++; $display("FAIL stray_next got %0d bytes want 1 byte 42", got_data.size()); end
    endtask

    task automatic test_timeout();
        clr(); m_ready = 1'b1; s_tick = 1'b0;
        send(8'h7E); send(8'h02); send(8'h11);
        repeat (639) tick();
        @(negedge clk);
        n_cmp++; if (ep_cnt != 0 || err_pulse !== 1'b0) begin n_err++; $display("FAIL tmo_639 got pulses %0d want 0", ep_cnt); end
        @(posedge clk); #1;
        tick();
        @(negedge clk);
        n_cmp++; if (err_pulse !== 1'b1) begin n_err++; $display("FAIL tmo_640_pulse got %b want 1", err_pulse); end
        n_cmp++; if (err_code !== 3'd4)  begin n_err++; $display("FAIL tmo_640_code got %0d want 4", err_code); end
        idle(2);
        // Byte on the expiry tick wins and restarts the count.
        clr();
        send(8'h7E); send(8'h02); send(8'h11);
        repeat (639) tick();
        s_tick = 1'b1; rx_data = 8'h22; rx_done_tick = 1'b1;
        @(posedge clk); #1;
        s_tick = 1'b0; rx_done_tick = 1'b0;
        idle(1);
        send(8'hCB); idle(4);
        n_cmp++; if (ep_cnt != 0 || fd_cnt != 1) begin n_err++; $display("FAIL tmo_race got ep %0d fd %0d want 0 1", ep_cnt, fd_cnt); end
        n_cmp++; if (got_data.size() != 2 || got_data[1] !== 8'h22 || got_last[1] !== 1'b1)
            begin n_err++; $display("FAIL tmo_race_data got %0d bytes want 11 22", got_data.size()); end
    endtask

    task automatic test_overflow();
        clr(); m_ready = 1'b0;
        send(8'h7E); send(8'h01); send(8'hAA); send(8'h55);
        send(8'h7E); send(8'h05); send(8'h01); send(8'h02); send(8'h03);
        n_cmp++; if (ep_cnt != 0) begin n_err++; $display("FAIL ovf_early got pulses %0d want 0", ep_cnt); end
        send(8'h04); idle(1);
        n_cmp++; if (ep_cnt != 1 || err_code !== 3'd5) begin n_err++; $display("FAIL ovf_4th got pulses %0d code %0d want 1 5", ep_cnt, err_code); end
        send(8'h05);
        n_cmp++; if (m_valid !== 1'b1 || m_data !== 8'hAA || m_last !== 1'b1)
            begin n_err++; $display("FAIL ovf_committed got v%b %h l%b want v1 aa l1", m_valid, m_data, m_last); end
        m_ready = 1'b1; idle(3);
        n_cmp++; if (got_data.size() != 1 || m_valid !== 1'b0) begin n_err++; $display("FAIL ovf_drain got %0d bytes want 1", got_data.size()); end
        m_ready = 1'b0; clr();
        send(8'h7E); send(8'h05); send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        n_cmp++; if (ep_cnt != 0) begin n_err++; $display("FAIL ovf_empty_4 got pulses %0d want 0", ep_cnt); end
        send(8'h05); idle(1);
        n_cmp++; if (ep_cnt != 1 || err_code !== 3'd5 || m_valid !== 1'b0)
            begin n_err++; $display("FAIL ovf_empty_5 got pulses %0d code %0d v%b want 1 5 0", ep_cnt, err_code, m_valid); end
    endtask

    task automatic test_parity();
        clr(); m_ready = 1'b1;
        send(8'h7E); send(8'h03); send(8'h11); send(8'h22, 1'b1); idle(3);
        n_cmp++; if (ep_cnt != 1 || err_code !== 3'd1 || mv_cnt != 0)
            begin n_err++; $display("FAIL parity got pulses %0d code %0d mv %0d want 1 1 0", ep_cnt, err_code, mv_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_d [3];
        logic       exp_l [3];
        exp_d = '{8'h05, 8'h01, 8'h02};
        exp_l = '{1'b1, 1'b0, 1'b1};
        clr(); m_ready = 1'b1;
        send(8'h7E); send(8'h01); send(8'h05); send(8'hFA);
        send(8'h7E); send(8'h02); send(8'h01); send(8'h02); send(8'hFB);
        idle(5);
        n_cmp++; if (fd_cnt != 2 || got_data.size() != 3) begin n_err++; $display("FAIL b2b got fd %0d bytes %0d want 2 3", fd_cnt, got_data.size()); end
        for (int i = 0; i < 3 && i < got_data.size(); i++) begin
            n_cmp++; if (got_data[i] !== exp_d[i] || got_last[i] !== exp_l[i])
                begin n_err++; $display("FAIL b2b[%0d] got %h/%b want %h/%b", i, got_data[i], got_last[i], exp_d[i], exp_l[i]); end
        end
    endtask

    task automatic test_reset_mid();
        clr(); m_ready = 1'b0;
        send(8'h7E); send(8'h01); send(8'hAA); send(8'h55);
        send(8'h7E); send(8'h03); send(8'h11);
        n_cmp++; if (m_valid !== 1'b1) begin n_err++; $display("FAIL rstmid_pre got v%b want 1", m_valid); end
        reset = 1'b1; #2;
        n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_m_valid got %b want 0", m_valid); end
        n_cmp++; if (dut.wr_ptr_q !== 3'd0 || dut.cm_ptr_q !== 3'd0 || dut.rd_ptr_q !== 3'd0)
            begin n_err++; $display("FAIL rstmid_ptrs got %0d %0d %0d want 0 0 0", dut.wr_ptr_q, dut.cm_ptr_q, dut.rd_ptr_q); end
        n_cmp++; if (dut.state_q !== 2'd0) begin n_err++; $display("FAIL rstmid_state got %0d want 0", dut.state_q); end
        @(posedge clk); #1; reset = 1'b0;
        clr(); m_ready = 1'b1;
        send(8'h22); send(8'h33); send(8'h7E); send(8'h01); send(8'h42); send(8'hBD); idle(4);
        n_cmp++; if (got_data.size() != 1 || got_data[0] !== 8'h42 || ep_cnt != 0)
            begin n_err++; $display("FAIL rstmid_after got %0d bytes ep %0d want 1 byte 42 ep 0", got_data.size(), ep_cnt); end
    endtask

    initial begin
        reset = 1'b1; s_tick = 1'b0; rx_done_tick = 1'b0; rx_data = 8'h00;
        rx_parity_err = 1'b0; m_ready = 1'b0;
        clr();
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        reset = 1'b0;
        idle(2);
        test_good_frame();
        test_bad_csum();
        test_len();
        test_stray();
        test_timeout();
        test_overflow();
        test_parity();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
